// File: rtl/cmi_codec_gen_if.sv
// Control, line and status signals of the CMI codec.
// The codec uses the slave modport; a driver or bench uses master.
interface cmi_codec_gen_if #(
  parameter int ERR_W = 8
);
  logic             en;
  logic             src_sel;
  logic             din;
  logic             line_in;
  logic             bit_stb;
  logic             z;
  logic             cmi;
  logic             cmo;
  logic             cmo_vld;
  logic             cv;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output en, src_sel, din, line_in,
    input  bit_stb, z, cmi, cmo, cmo_vld, cv, err_cnt
  );

  modport slave (
    input  en, src_sel, din, line_in,
    output bit_stb, z, cmi, cmo, cmo_vld, cv, err_cnt
  );
endinterface

// File: rtl/cmi_codec_gen.sv
// CMI codec: PN or external source, OVS-oversampled CMI encoder, and a
// two-point pair decoder with code-violation detection and saturating count.
module cmi_codec_gen #(
  parameter int OVS    = 8,
  parameter int PN_LEN = 4,
  parameter int RX_LAT = 0,
  parameter int ERR_W  = 8
) (
  input  logic           i_cp,
  input  logic           i_rst,
  cmi_codec_gen_if.slave io_bus
);
  localparam int S_W   = (OVS > 2) ? $clog2(OVS) : 1;
  localparam int A_OFF = (1 + OVS / 4 + RX_LAT) % OVS;
  localparam int D_RST = (OVS - A_OFF) % OVS;
  localparam int TAP_B = (PN_LEN <= 5) ? 2 : (PN_LEN - 2);

  localparam logic [S_W-1:0]   S_ZERO   = {S_W{1'b0}};
  localparam logic [S_W-1:0]   S_LAST   = S_W'(OVS - 1);
  localparam logic [S_W-1:0]   S_HALF   = S_W'(OVS / 2);
  localparam logic [S_W-1:0]   DPH_RST  = S_W'(D_RST);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  // Fibonacci step: shift left, tap pair XOR into bit 0.
  function automatic logic [PN_LEN-1:0] lfsr_next(input logic [PN_LEN-1:0] v);
    return {v[PN_LEN-2:0], v[PN_LEN-1] ^ v[TAP_B]};
  endfunction

  logic [S_W-1:0]    r_s, w_s_nxt;
  logic [S_W-1:0]    r_dph, w_dph_nxt;
  logic [PN_LEN-1:0] r_lfsr;
  logic              r_z, r_l, r_cmi;
  logic              w_s_last, w_cmi_nxt;

  logic              r_a, r_have_a, r_primed, r_rl, r_rl_vld;
  logic              r_cmo, r_cmo_vld, r_cv;
  logic [ERR_W-1:0]  r_err, w_err_nxt;
  logic              w_samp_a, w_samp_b, w_pair;
  logic              w_cmo_nxt, w_vld_nxt, w_cv_nxt;
  logic              w_rl_nxt, w_rl_vld_nxt, w_primed_nxt;

  // Phase counters and encoder next level.
  always_comb begin
    w_s_last  = (r_s == S_LAST);
    w_s_nxt   = r_s + S_W'(1);
    w_dph_nxt = r_dph + S_W'(1);
    w_cmi_nxt = 1'b0;
    if (w_s_last) begin
      w_s_nxt = S_ZERO;
    end else begin
      w_s_nxt = r_s + S_W'(1);
    end
    if (r_dph == S_LAST) begin
      w_dph_nxt = S_ZERO;
    end else begin
      w_dph_nxt = r_dph + S_W'(1);
    end
    if (r_z) begin
      w_cmi_nxt = ~r_l;
    end else begin
      w_cmi_nxt = (r_s >= S_HALF);
    end
  end

  // Source selection, PN advance and line encoder state.
  always_ff @(posedge i_cp or posedge i_rst) begin
    if (i_rst) begin
      r_s    <= S_ZERO;
      r_lfsr <= {PN_LEN{1'b1}};
      r_z    <= 1'b0;
      r_l    <= 1'b0;
      r_cmi  <= 1'b0;
    end else if (io_bus.en) begin
      r_s   <= w_s_nxt;
      r_cmi <= w_cmi_nxt;
      if (w_s_last) begin
        r_z    <= io_bus.src_sel ? io_bus.din : r_lfsr[PN_LEN-1];
        r_lfsr <= lfsr_next(r_lfsr);
        r_l    <= r_l ^ r_z;
      end
    end
  end

  // The decoder phase runs at a fixed offset so A lands on phase 0.
  assign w_samp_a = (r_dph == S_ZERO);
  assign w_samp_b = (r_dph == S_HALF);
  assign w_pair   = w_samp_b & r_have_a;

  // Pair classification on the B sample.
  always_comb begin
    w_cmo_nxt    = r_cmo;
    w_vld_nxt    = 1'b0;
    w_cv_nxt     = 1'b0;
    w_rl_nxt     = r_rl;
    w_rl_vld_nxt = r_rl_vld;
    w_primed_nxt = r_primed;
    if (w_pair) begin
      if (!r_primed) begin
        w_primed_nxt = 1'b1;
      end else begin
        w_vld_nxt = 1'b1;
        case ({r_a, io_bus.line_in})
          2'b01: begin
            w_cmo_nxt = 1'b0;
          end
          2'b10: begin
            w_cmo_nxt = 1'b0;
            w_cv_nxt  = 1'b1;
          end
          default: begin
            w_cmo_nxt    = 1'b1;
            w_cv_nxt     = r_rl_vld & (r_rl == r_a);
            w_rl_nxt     = r_a;
            w_rl_vld_nxt = 1'b1;
          end
        endcase
      end
    end else begin
      w_vld_nxt = 1'b0;
    end
    if (w_cv_nxt && (r_err != ERR_MAX)) begin
      w_err_nxt = r_err + ERR_W'(1);
    end else begin
      w_err_nxt = r_err;
    end
  end

  // Decoder state and registered decoder outputs.
  always_ff @(posedge i_cp or posedge i_rst) begin
    if (i_rst) begin
      r_dph     <= DPH_RST;
      r_a       <= 1'b0;
      r_have_a  <= 1'b0;
      r_primed  <= 1'b0;
      r_rl      <= 1'b0;
      r_rl_vld  <= 1'b0;
      r_cmo     <= 1'b0;
      r_cmo_vld <= 1'b0;
      r_cv      <= 1'b0;
      r_err     <= {ERR_W{1'b0}};
    end else if (io_bus.en) begin
      r_dph     <= w_dph_nxt;
      if (w_samp_a) begin
        r_a <= io_bus.line_in;
      end
      r_have_a  <= r_have_a | w_samp_a;
      r_primed  <= w_primed_nxt;
      r_rl      <= w_rl_nxt;
      r_rl_vld  <= w_rl_vld_nxt;
      r_cmo     <= w_cmo_nxt;
      r_cmo_vld <= w_vld_nxt;
      r_cv      <= w_cv_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Strobes are gated so a frozen codec never presents a pulse.
  assign io_bus.bit_stb = io_bus.en & (r_s == S_ZERO);
  assign io_bus.z       = r_z;
  assign io_bus.cmi     = r_cmi;
  assign io_bus.cmo     = r_cmo;
  assign io_bus.cmo_vld = io_bus.en & r_cmo_vld;
  assign io_bus.cv      = io_bus.en & r_cv;
  assign io_bus.err_cnt = r_err;

endmodule
